// File: rtl/ifu_axi_rd_bridge_pkg.sv
// Shared definitions for the instruction-fetch AXI4-Lite read bridge.
//   state_t        : bridge FSM states
//   AXI_RESP_OKAY  : AXI response code for a successful read
//   FAULT_INST     : instruction returned on a faulted fetch (addi x0,x0,0)
//   resp_is_err()  : true for any AXI response other than OKAY
package ifu_axi_rd_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,   // waiting for a fetch request
        AR,     // read address presented, waiting for arready
        R,      // address accepted, waiting for read data
        DROP,   // waiting for read data that will be thrown away
        HOLD    // word presented to fetch, waiting for ready/flush
    } state_t;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [31:0] FAULT_INST    = 32'h0000_0013;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ifu_axi_rd_bridge.sv
// Instruction-side bridge between the fetch stage and an AXI4-Lite read port.
// A level request plus pc becomes a single AR/R transaction; the returned word
// is held on rvalid/rdata/rfault until fetch takes it (ready) or redirects
// (flush). At most one read is outstanding. A flush during the address or
// data phase turns the transaction into a drop: the bus handshake is still
// completed but the data never reaches fetch.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req, pc             fetch request and address (pc sampled in IDLE only)
//   flush               pipeline redirect, kills any fetch in progress
//   ready               fetch side accepts the current word
//   rvalid/rdata/rfault registered word to fetch; rfault marks misaligned pc
//                       or non-OKAY response (rdata is then FAULT_INST)
//   m_ar*               AXI read address channel (master side)
//   m_r*                AXI read data channel (master side)
module ifu_axi_rd_bridge #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  FAULT_INST = ifu_axi_rd_bridge_pkg::FAULT_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              rfault,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);
    import ifu_axi_rd_bridge_pkg::*;

    state_t state;
    // Sticky: a flush was seen while the address was outstanding, so the
    // response must be dropped once the address is accepted.
    logic   kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            kill      <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rfault    <= 1'b0;
            m_araddr  <= '0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !flush) begin
                        if (pc[1:0] == 2'b00) begin
                            m_araddr  <= pc;
                            m_arvalid <= 1'b1;
                            kill      <= 1'b0;
                            state     <= AR;
                        end else begin
                            // Misaligned: fault locally, never touch the bus.
                            rdata  <= FAULT_INST;
                            rfault <= 1'b1;
                            rvalid <= 1'b1;
                            state  <= HOLD;
                        end
                    end
                end

                AR: begin
                    // arvalid/araddr must not change until the handshake.
                    if (flush)
                        kill <= 1'b1;
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= (kill || flush) ? DROP : R;
                    end
                end

                R: begin
                    if (m_rvalid) begin
                        m_rready <= 1'b0;
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            rvalid <= 1'b1;
                            rfault <= resp_is_err(m_rresp);
                            rdata  <= resp_is_err(m_rresp) ? FAULT_INST : m_rdata;
                            state  <= HOLD;
                        end
                    end else if (flush) begin
                        // Data still owed by the slave; keep rready up and
                        // swallow it.
                        state <= DROP;
                    end
                end

                DROP: begin
                    if (m_rvalid) begin
                        m_rready <= 1'b0;
                        kill     <= 1'b0;
                        state    <= IDLE;
                    end
                end

                HOLD: begin
                    if (ready || flush) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
